conv3x3_window_gen: RTL
=======================

Name: conv3x3_window_gen

Overview:
- Streaming 3x3 sliding-window generator directly upstream of the 4-lane conv3x3 wrapper.
- Accepts one raster-order pixel per valid cycle and keeps two line buffers plus a 3x3 register window.
- Emits each fully-populated 3x3 window (stride 1, no padding) with a valid strobe.
- Emits a one-cycle map-done pulse after the last window of the frame; the conv stage uses this pulse to advance its output-channel phase.

Parameters:
- WI, 8, pixel width in bits (signed data, passed through unmodified).
- IMG_W, 28, frame width in pixels; must be >= 3.
- IMG_H, 28, frame height in pixels; must be >= 3.

Ports:
- iClk  input  1  clock.
- iRsn  input  1  reset, synchronous, active-low.
- iPixValid  input  1  iPixData is valid this cycle; may drop at any time (bubbles allowed, no backpressure).
- iPixData  input  WI  pixel, raster order (row 0 col 0 first).
- oWindowRow1  output  3*WI  top window row (oldest line): {p(y-2,x-2), p(y-2,x-1), p(y-2,x)}, MSB = leftmost.
- oWindowRow2  output  3*WI  middle row: {p(y-1,x-2), p(y-1,x-1), p(y-1,x)}.
- oWindowRow3  output  3*WI  bottom row: {p(y,x-2), p(y,x-1), p(y,x)}.
- oWinValid  output  1  window outputs valid this cycle.
- oMapDone  output  1  one-cycle pulse after the last window of a frame.

Behaviour:
- Reset: one clock, iClk; iRsn is synchronous, active-low.
  - While iRsn=0: col/row counters = 0, oWinValid = 0, oMapDone = 0, window outputs = 0.
  - Line-buffer RAM contents are not cleared; validity is gated purely by the counters.
- Counters: col in [0, IMG_W-1], row in [0, IMG_H-1], each $clog2 width.
  - Both advance only on iPixValid=1.
  - col wraps to 0 at IMG_W-1, and row increments at that point.
  - At (IMG_H-1, IMG_W-1), both wrap to 0; the next pixel is row 0 col 0 of the next frame. Back-to-back frames need no gap.
- Line buffers: two buffers of depth IMG_W holding rows y-1 and y-2, read/written at index col.
  - On each accepted pixel, the column {lb2[col], lb1[col], iPixData} shifts into the right edge of the 3x3 window; the leftmost column is discarded.
  - Buffer update: lb2[col] <= lb1[col], lb1[col] <= iPixData.
- Window valid: for an accepted pixel at (row, col) with row >= 2 and col >= 2:
  - oWinValid = 1 on the next cycle, with registered window outputs; latency is exactly 1 cycle from pixel acceptance.
  - Otherwise oWinValid = 0 next cycle.
  - Window outputs hold their value when oWinValid = 0.
- Window count per frame: (IMG_H-2)*(IMG_W-2). Windows never straddle a row wrap, because col < 2 is masked.
- Map done: oMapDone = 1 exactly one cycle after the oWinValid cycle of the last window (row = IMG_H-1, col = IMG_W-1), independent of iPixValid that cycle.
  - It is never coincident with oWinValid of the same frame.
  - It may coincide with oWinValid only if IMG_W <= 2, which is excluded by the parameter constraint.
- Bubbles: iPixValid = 0 freezes counters, line buffers and the window; no output valid is generated.
- Reset mid-frame: counters return to 0. The next accepted pixel is treated as (0,0); no windows are emitted until 2 rows + 3 pixels of the new frame have been accepted. Stale buffer data never reaches a valid output.
- Data is passed bit-exact; no arithmetic on pixel values.

Test Plan:
- Basic frame, IMG_W=5, IMG_H=4, pixel = y*5+x, continuous valid:
  - Exactly 6 oWinValid pulses.
  - First window: R1 = {0,1,2}, R2 = {5,6,7}, R3 = {10,11,12}, one cycle after pixel 12 is accepted.
  - Last window: R1 = {7,8,9}, R2 = {12,13,14}, R3 = {17,18,19}.
  - oMapDone high exactly one cycle after the last window.
- Same frame with random 50% iPixValid bubbles -> identical window sequence and count; each valid exactly 1 cycle after its triggering pixel; oMapDone still one pulse.
- Two back-to-back frames, second pixel = 100+y*5+x -> second frame's first window R1 = {100,101,102}, R3 = {110,111,112}; no window emitted spanning the frame boundary; 2 oMapDone pulses in total.
- Reset asserted after pixel 13 of a frame, then a fresh frame -> outputs zero during reset; no valid until the new pixel 12; windows contain only new-frame data.
- Default 28x28 frame -> 676 windows, 1 oMapDone.
  - Windows checked against a reference model.
  - Four frames replayed produce 4 oMapDone pulses, stepping the downstream phase 0 -> 1 -> 2 -> 3 -> 0.
- Signed extremes, pixels alternating 8'h80/8'h7F -> window outputs bit-exact, with no sign extension or alteration.

Source files
------------

// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen
//   Streaming 3x3 sliding-window generator (stride 1, no padding) that sits in
//   front of the conv3x3 stage. It accepts raster-order pixels and keeps two
//   line buffers plus two columns of window history. For every pixel at
//   (row>=2, col>=2) it emits one registered 3x3 window on the following cycle.
//
// Ports
//   iClk         clock
//   iRsn         synchronous active-low reset
//   iPixValid    iPixData valid (bubbles allowed, no backpressure)
//   iPixData     pixel, WI bits, passed bit-exact
//   oWindowRow1  {p(y-2,x-2), p(y-2,x-1), p(y-2,x)}, MSB = leftmost
//   oWindowRow2  {p(y-1,x-2), p(y-1,x-1), p(y-1,x)}
//   oWindowRow3  {p(y,  x-2), p(y,  x-1), p(y,  x)}
//   oWinValid    window outputs valid this cycle
//   oMapDone     one-cycle pulse the cycle after the last window of a frame
module conv3x3_window_gen #(
  parameter int WI    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            iClk,
  input  logic            iRsn,
  input  logic            iPixValid,
  input  logic [WI-1:0]   iPixData,
  output logic [3*WI-1:0] oWindowRow1,
  output logic [3*WI-1:0] oWindowRow2,
  output logic [3*WI-1:0] oWindowRow3,
  output logic            oWinValid,
  output logic            oMapDone
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2 at index col.
  logic [WI-1:0] lb1 [IMG_W];
  logic [WI-1:0] lb2 [IMG_W];

  // Window history columns, index 2 = top (y-2), 1 = middle, 0 = bottom (y).
  // hm1 is column x-1, hm2 is column x-2 relative to the incoming pixel.
  logic [2:0][WI-1:0] hm1_q, hm2_q, col_new;

  logic col_last, row_last, win_fire, last_win, last_q;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign col_new  = {lb2[col_q], lb1[col_q], iPixData};

  // Masking col < 2 keeps windows from straddling a row wrap; masking
  // row < 2 keeps stale line-buffer contents (e.g. after reset) out.
  assign win_fire = iPixValid && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign last_win = win_fire && col_last && row_last;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (iPixValid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      col_q       <= '0;
      row_q       <= '0;
      hm1_q       <= '0;
      hm2_q       <= '0;
      oWindowRow1 <= '0;
      oWindowRow2 <= '0;
      oWindowRow3 <= '0;
      oWinValid   <= 1'b0;
      last_q      <= 1'b0;
      oMapDone    <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      oWinValid <= win_fire;
      last_q    <= last_win;
      // Done trails the last window's valid by one cycle regardless of input.
      oMapDone  <= last_q;
      if (iPixValid) begin
        hm2_q <= hm1_q;
        hm1_q <= col_new;
      end
      if (win_fire) begin
        oWindowRow1 <= {hm2_q[2], hm1_q[2], col_new[2]};
        oWindowRow2 <= {hm2_q[1], hm1_q[1], col_new[1]};
        oWindowRow3 <= {hm2_q[0], hm1_q[0], col_new[0]};
      end
    end
  end

  // Line buffers are not reset; validity is gated by the counters alone.
  always_ff @(posedge iClk) begin
    if (iPixValid) begin
      lb2[col_q] <= lb1[col_q];
      lb1[col_q] <= iPixData;
    end
  end

endmodule
